uart_tx_fifo_gen: RTL

Parametrised, run-time-configurable UART transmitter that replaces the fixed 8-bit single-buffer transmitter in the low-power link. It has an internal bit-rate prescaler and selectable data length, parity and stop-bit count. A small input FIFO with a valid/ready handshake supports back-to-back frames. It sits between the system-side data producer and the serial line pin.

---
 rtl/uart_tx_fifo_gen_pkg.sv | 23 ++
 rtl/uart_tx_fifo_gen_fifo.sv | 58 +++++
 rtl/uart_tx_fifo_gen.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_gen_pkg.sv
// Shared types and constants for the FIFO-fed, run-time-configurable UART transmitter.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP1  = 3'd4,
      ST_STOP2  = 3'd5
   } tx_state_e;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;
   localparam int   MIN_LEN     = 5;

   // Bit periods in one frame: start + data + optional parity + one or two stops.
   function automatic logic [4:0] frame_bits(input logic [3:0] len, input logic par_en,
                                             input logic stop2);
      return 5'd2 + {1'b0, len} + {4'b0000, par_en} + {4'b0000, stop2};
   endfunction

endpackage

// File: rtl/uart_tx_fifo_gen_fifo.sv
// Small synchronous FIFO with a combinational head output and an occupancy count.
module sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  logic [W-1:0]                   din,
   input  logic                           pop,
   output logic [W-1:0]                   dout,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [CW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] rd_ptr_q, rd_ptr_d;
   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];

   assign count = wr_ptr_q - rd_ptr_q;
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (push && !full) begin
         mem_d[wr_ptr_q[AW-1:0]] = din;
         wr_ptr_d = wr_ptr_q + CW'(1);
      end
      if (pop && !empty) begin
         rd_ptr_d = rd_ptr_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/uart_tx_fifo_gen.sv
// UART transmitter fed by a valid/ready FIFO; frame format and bit period are
// sampled from the config inputs at the moment each word is popped.
module uart_tx_fifo_gen
   import uart_tx_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 4,
   parameter int PRESC_W = 16
) (
   input  logic                          CLK,
   input  logic                          Reset,
   input  logic                          Data_valid,
   input  logic [WIDTH-1:0]              Data,
   output logic                          Ready,
   input  logic [3:0]                    Data_len,
   input  logic                          Parity_EN,
   input  logic                          Parity_type,
   input  logic                          Stop2,
   input  logic [PRESC_W-1:0]            Prescale,
   output logic                          Tx_out,
   output logic                          Busy,
   output logic [$clog2(DEPTH+1)-1:0]    Fifo_count,
   output logic [2:0]                    dbg_state
);

   // Handshake: a word is accepted on a CLK edge where Data_valid && Ready;
   // Ready is low only while the FIFO is full, and Data is ignored then.
   logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [WIDTH-1:0] fifo_dout;

   tx_state_e           state_q, state_d;
   logic [PRESC_W-1:0]  cnt_q, cnt_d;
   logic [PRESC_W-1:0]  presc_q, presc_d;
   logic [3:0]          bits_q, bits_d;
   logic [WIDTH-1:0]    shreg_q, shreg_d;
   logic                par_q, par_d;
   logic                par_en_q, par_en_d;
   logic                stop2_q, stop2_d;
   logic                tx_q, tx_d;
   logic                busy_q, busy_d;
   logic                bit_done;
   logic                load_next;

   assign Ready     = !fifo_full;
   assign fifo_push = Data_valid && Ready;

   sync_fifo #(.W(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (CLK),
      .rst   (Reset),
      .push  (fifo_push),
      .din   (Data),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (Fifo_count)
   );

   function automatic logic [3:0] clamp_len(input logic [3:0] len);
      if (int'(len) < MIN_LEN || int'(len) > WIDTH) return 4'(WIDTH);
      return len;
   endfunction

   function automatic logic calc_parity(input logic [WIDTH-1:0] d, input logic [3:0] len,
                                        input logic ptype);
      logic p;
      p = (ptype == PARITY_ODD);
      for (int i = 0; i < WIDTH; i++) begin
         if (i < int'(len)) p = p ^ d[i];
      end
      return p;
   endfunction

   assign bit_done = (cnt_q == '0);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      presc_d   = presc_q;
      bits_d    = bits_q;
      shreg_d   = shreg_q;
      par_d     = par_q;
      par_en_d  = par_en_q;
      stop2_d   = stop2_q;
      fifo_pop  = 1'b0;
      load_next = 1'b0;
      tx_d      = 1'b1;

      // Every state entry and every new data bit reloads the period counter.
      if (state_q != ST_IDLE) begin
         cnt_d = bit_done ? presc_q : cnt_q - PRESC_W'(1);
      end

      case (state_q)
         ST_IDLE:   load_next = 1'b1;
         ST_START:  if (bit_done) state_d = ST_DATA;
         ST_DATA: begin
            if (bit_done) begin
               if (bits_q == 4'd1) begin
                  state_d = par_en_q ? ST_PARITY : ST_STOP1;
               end else begin
                  shreg_d = shreg_q >> 1;
                  bits_d  = bits_q - 4'd1;
               end
            end
         end
         ST_PARITY: if (bit_done) state_d = ST_STOP1;
         ST_STOP1: begin
            if (bit_done) begin
               if (stop2_q) state_d = ST_STOP2;
               else         load_next = 1'b1;
            end
         end
         ST_STOP2:  if (bit_done) load_next = 1'b1;
         default:   state_d = ST_IDLE;
      endcase

      // Frame boundary: chain straight into the next queued word, else go idle.
      if (load_next) begin
         if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_START;
            shreg_d  = fifo_dout;
            bits_d   = clamp_len(Data_len);
            par_d    = calc_parity(fifo_dout, clamp_len(Data_len), Parity_type);
            par_en_d = Parity_EN;
            stop2_d  = Stop2;
            presc_d  = Prescale;
            cnt_d    = Prescale;
         end else begin
            state_d = ST_IDLE;
         end
      end

      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shreg_d[0];
         ST_PARITY: tx_d = par_d;
         default:   tx_d = 1'b1;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         presc_q  <= '0;
         bits_q   <= '0;
         shreg_q  <= '0;
         par_q    <= 1'b0;
         par_en_q <= 1'b0;
         stop2_q  <= 1'b0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         presc_q  <= presc_d;
         bits_q   <= bits_d;
         shreg_q  <= shreg_d;
         par_q    <= par_d;
         par_en_q <= par_en_d;
         stop2_q  <= stop2_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
      end
   end

   assign Tx_out    = tx_q;
   assign Busy      = busy_q;
   assign dbg_state = state_q;

endmodule
